memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Memory-side responder for the CPU request unit: accepts the instruction-fetch request (imemREN) and the data request (dmemREN/dmemWEN), serialises them onto the single-ported RAM interface, and returns ihit/dhit with load data. It sits between the datapath's request unit and RAM and owns arbitration priority, RAM handshake, transaction latching and timeout detection.

## Interface
- WORD_W, 32, data and address width
- TIMEOUT, 64, maximum cycles an access may wait for RAM ACCESS before the error state is entered (≥2)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  instruction read request (level)
- imemaddr  in  WORD_W  instruction address
- dmemREN  in  1  data read request (level)
- dmemWEN  in  1  data write request (level); wins over dmemREN if both are high
- dmemaddr  in  WORD_W  data address
- dmemstore  in  WORD_W  data write value
- ihit  out  1  instruction access complete, one-cycle pulse
- imemload  out  WORD_W  instruction word, valid while ihit=1
- dhit  out  1  data access complete, one-cycle pulse
- dmemload  out  WORD_W  load word, valid while dhit=1 on a read
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- memerr  out  1  sticky error flag

## Operation
- States: IDLE, DACC, IACC, ERR.
- IDLE: if (dmemREN|dmemWEN) and not (ifirst & imemREN) -> DACC; else if imemREN -> IACC; else stay. On entry, latch address, store data and write flag (dmemWEN) into internal registers; clear timeout counter.
- ifirst: set on the edge leaving DACC with dhit; cleared on the edge leaving IDLE. Gives one instruction grant after each data completion (anti-starvation); otherwise data has priority.
- DACC/IACC: ramaddr/ramstore from latched registers; DACC drives ramWEN=wflag, ramREN=!wflag; IACC drives ramREN=1. Requestor inputs are ignored after latching; a dropped request still completes and still pulses its hit.
- Completion: ramstate==ACCESS in DACC -> dhit=1 that cycle (combinational), dmemload=ramload; next edge -> IDLE. Same in IACC with ihit/imemload.
- Timeout: counter (clog2(TIMEOUT+1) bits) increments each access cycle without ACCESS; if counter==TIMEOUT-1 and ramstate!=ACCESS, next state ERR. ramstate==ERROR in DACC/IACC -> ERR on the next edge, no hit.
- ERR: ramREN=ramWEN=0, ihit=dhit=0, memerr=1; exits only by nRST.
- Outputs outside access states: ramREN=ramWEN=0; ramaddr/ramstore hold latched values; imemload/dmemload=ramload (don't-care when hit low).

## Timing
- Reset (async): state=IDLE, ifirst=0, counter=0, latched addr/store/wflag=0; hence ihit=dhit=0, ramREN=ramWEN=0, ramaddr=ramstore=0, memerr=0.
- Request high at edge k in IDLE -> RAM strobes from cycle k+1 -> hit in the first cycle with ramstate==ACCESS; minimum latency request-to-hit = 1 cycle after acceptance edge.
- Hit lasts exactly one cycle; state is IDLE on the following cycle, so a request unit that clears its request on the hit edge never causes a re-issue.
- Requests arriving during DACC/IACC wait; simultaneous i/d requests in IDLE: data first (unless ifirst), instruction granted next.
- nRST mid-transaction: immediate abort, all outputs to reset values; no hit pulsed.

## Test plan
- Reset: hold nRST low with imemREN=1, ramstate=ACCESS -> ihit=dhit=0, ramREN=ramWEN=0, memerr=0.
- Fetch: imemREN=1, imemaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40, ihit one cycle with imemload=0x8C010004.
- Priority: imemREN=1 and dmemREN=1 (dmemaddr=0x100) together from IDLE -> ramaddr=0x100 first, dhit, then IACC at 0x40 even though dmemREN re-asserted, ihit.
- Write: dmemWEN=1, dmemaddr=0x200, dmemstore=0xDEADBEEF, dmemREN=1 too -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit on ACCESS; dropping dmemWEN mid-wait still yields dhit.
- Timeout/error: TIMEOUT=4, ramstate held BUSY -> ERR after 4 access cycles, memerr=1, no hit; separate run with ramstate=ERROR -> ERR next edge.
- Reset mid-op: assert nRST low during DACC wait -> outputs at reset values immediately; after release, new fetch completes normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// Memory-side arbiter: serialises instruction fetches and data accesses onto a
// single-ported RAM, returning one-cycle hit pulses with load data.
module memory_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} state_t;

    state_t            state, state_n;
    logic              ifirst, ifirst_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [WORD_W-1:0] addr_q, addr_n;
    logic [WORD_W-1:0] store_q, store_n;
    logic              wflag_q, wflag_n;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ifirst  <= 1'b0;
            count   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wflag_q <= 1'b0;
        end else begin
            state   <= state_n;
            ifirst  <= ifirst_n;
            count   <= count_n;
            addr_q  <= addr_n;
            store_q <= store_n;
            wflag_q <= wflag_n;
        end
    end

    // Data wins in IDLE unless the previous grant was data and a fetch waits.
    always_comb begin
        state_n  = state;
        ifirst_n = ifirst;
        count_n  = count;
        addr_n   = addr_q;
        store_n  = store_q;
        wflag_n  = wflag_q;
        ihit     = 1'b0;
        dhit     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        case (state)
            IDLE: begin
                if ((dmemREN || dmemWEN) && !(ifirst && imemREN)) begin
                    state_n  = DACC;
                    addr_n   = dmemaddr;
                    store_n  = dmemstore;
                    wflag_n  = dmemWEN;
                    count_n  = '0;
                    ifirst_n = 1'b0;
                end else if (imemREN) begin
                    state_n  = IACC;
                    addr_n   = imemaddr;
                    wflag_n  = 1'b0;
                    count_n  = '0;
                    ifirst_n = 1'b0;
                end
            end
            DACC: begin
                ramWEN = wflag_q;
                ramREN = !wflag_q;
                if (ramstate == RAM_ACCESS) begin
                    dhit     = 1'b1;
                    state_n  = IDLE;
                    ifirst_n = 1'b1;
                end else if (ramstate == RAM_ERROR || count == CNT_LAST) begin
                    state_n = ERR;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            IACC: begin
                ramREN = 1'b1;
                if (ramstate == RAM_ACCESS) begin
                    ihit    = 1'b1;
                    state_n = IDLE;
                end else if (ramstate == RAM_ERROR || count == CNT_LAST) begin
                    state_n = ERR;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign imemload = ramload;
    assign dmemload = ramload;
    assign memerr   = (state == ERR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level priority model.
module tb_memory_arbiter;

    localparam int W  = 32;
    localparam int TO = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, RERR = 2'd3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         imemREN, dmemREN, dmemWEN;
    logic [W-1:0] imemaddr, dmemaddr, dmemstore;
    logic         ihit, dhit, ramREN, ramWEN, memerr;
    logic [W-1:0] imemload, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]   ramstate;

    int total = 0;
    int bad   = 0;
    bit ifirst_m;

    memory_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        ramstate = FREE;
        #2;
        nRST = 1'b1;
        tick();
        ifirst_m = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        imemREN = 1'b1; imemaddr = 32'h40;
        dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'h0; dmemstore = 32'h0;
        ramstate = ACCESS; ramload = 32'hCAFE0000;
        #3;
        tick();
        total++;
        if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got ihit,dhit,ren,wen,err=%b exp=00000",
                     {ihit, dhit, ramREN, ramWEN, memerr});
        end
        total++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_bus got addr=%h store=%h exp=0", ramaddr, ramstore);
        end
        imemREN = 1'b0; ramstate = FREE;
        nRST = 1'b1;
        tick();
        ifirst_m = 1'b0;
    endtask

    task automatic test_fetch;
        imemREN = 1'b1; imemaddr = 32'h40; ramstate = FREE;
        tick();
        for (int c = 0; c < 2; c++) begin
            ramstate = BUSY;
            #1;
            total++;
            if ({ramREN, ramWEN, ihit, dhit} !== 4'b1000 || ramaddr !== 32'h40) begin
                bad++;
                $display("[TB] FAIL fetch_wait got ren,wen,ihit,dhit=%b addr=%h exp=1000 addr=40",
                         {ramREN, ramWEN, ihit, dhit}, ramaddr);
            end
            tick();
        end
        ramstate = ACCESS; ramload = 32'h8C010004;
        #1;
        total++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || imemload !== 32'h8C010004) begin
            bad++;
            $display("[TB] FAIL fetch_hit got ihit=%b dhit=%b load=%h exp=1 0 8c010004",
                     ihit, dhit, imemload);
        end
        imemREN = 1'b0;
        tick();
        ramstate = FREE;
        #1;
        total++;
        if ({ihit, ramREN} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL fetch_single_pulse got ihit,ren=%b exp=00", {ihit, ramREN});
        end
        ifirst_m = 1'b0;
    endtask

    task automatic test_priority;
        imemREN = 1'b1; imemaddr = 32'h40;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        tick();
        ramstate = ACCESS; ramload = 32'h11111111;
        #1;
        total++;
        if (ramaddr !== 32'h100 || {dhit, ihit} !== 2'b10 || dmemload !== 32'h11111111) begin
            bad++;
            $display("[TB] FAIL prio_data_first got addr=%h dhit,ihit=%b load=%h exp=100 10 11111111",
                     ramaddr, {dhit, ihit}, dmemload);
        end
        tick();
        ramstate = FREE;
        #1;
        total++;
        if ({dhit, ihit, ramREN} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL prio_idle_gap got dhit,ihit,ren=%b exp=000", {dhit, ihit, ramREN});
        end
        tick();
        ramstate = ACCESS; ramload = 32'h22222222;
        #1;
        total++;
        if (ramaddr !== 32'h40 || {ihit, dhit} !== 2'b10 || imemload !== 32'h22222222) begin
            bad++;
            $display("[TB] FAIL prio_inst_next got addr=%h ihit,dhit=%b load=%h exp=40 10 22222222",
                     ramaddr, {ihit, dhit}, imemload);
        end
        imemREN = 1'b0; dmemREN = 1'b0;
        tick();
        ramstate = FREE;
        ifirst_m = 1'b0;
    endtask

    task automatic test_write;
        dmemWEN = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'hDEADBEEF;
        tick();
        ramstate = BUSY;
        #1;
        total++;
        if ({ramWEN, ramREN} !== 2'b10 || ramaddr !== 32'h200 || ramstore !== 32'hDEADBEEF || dhit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_strobe got wen,ren=%b addr=%h store=%h dhit=%b exp=10 200 deadbeef 0",
                     {ramWEN, ramREN}, ramaddr, ramstore, dhit);
        end
        dmemWEN = 1'b0; dmemREN = 1'b0; dmemstore = 32'h0; dmemaddr = 32'h0;
        tick();
        ramstate = ACCESS;
        #1;
        total++;
        if (dhit !== 1'b1 || ramstore !== 32'hDEADBEEF || ramWEN !== 1'b1) begin
            bad++;
            $display("[TB] FAIL write_dropped_hit got dhit=%b store=%h wen=%b exp=1 deadbeef 1",
                     dhit, ramstore, ramWEN);
        end
        tick();
        ramstate = FREE;
        ifirst_m = 1'b1;
    endtask

    task automatic test_timeout;
        do_reset();
        dmemREN = 1'b1; dmemaddr = 32'h300;
        tick();
        for (int c = 0; c < TO; c++) begin
            ramstate = BUSY;
            #1;
            total++;
            if ({ramREN, dhit, memerr} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL timeout_wait%0d got ren,dhit,err=%b exp=100", c, {ramREN, dhit, memerr});
            end
            tick();
        end
        ramstate = ACCESS;
        #1;
        total++;
        if ({memerr, ramREN, ramWEN, dhit, ihit} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL timeout_err got err,ren,wen,dhit,ihit=%b exp=10000",
                     {memerr, ramREN, ramWEN, dhit, ihit});
        end
        dmemREN = 1'b0;
        tick();
        total++;
        if (memerr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_sticky got err=%b exp=1", memerr);
        end
        do_reset();
    endtask

    task automatic test_error_state;
        imemREN = 1'b1; imemaddr = 32'h44;
        tick();
        ramstate = RERR;
        #1;
        total++;
        if ({ihit, ramREN, memerr} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL ramerr_cycle got ihit,ren,err=%b exp=010", {ihit, ramREN, memerr});
        end
        imemREN = 1'b0;
        tick();
        total++;
        if ({memerr, ramREN, ihit} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL ramerr_enter got err,ren,ihit=%b exp=100", {memerr, ramREN, ihit});
        end
        do_reset();
    endtask

    task automatic test_reset_mid_op;
        logic [W-1:0] ld;
        dmemWEN = 1'b1; dmemaddr = 32'h500; dmemstore = 32'h1234;
        tick();
        ramstate = BUSY;
        #1;
        total++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h500) begin
            bad++;
            $display("[TB] FAIL midrst_pre got wen=%b addr=%h exp=1 500", ramWEN, ramaddr);
        end
        #1;
        nRST = 1'b0; ramstate = ACCESS;
        #1;
        total++;
        if ({dhit, ihit, ramREN, ramWEN, memerr} !== 5'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midrst_abort got dhit,ihit,ren,wen,err=%b addr=%h store=%h exp=0",
                     {dhit, ihit, ramREN, ramWEN, memerr}, ramaddr, ramstore);
        end
        dmemWEN = 1'b0; ramstate = FREE;
        nRST = 1'b1;
        tick();
        ifirst_m = 1'b0;
        imemREN = 1'b1; imemaddr = 32'h80;
        tick();
        ld = $urandom;
        ramstate = ACCESS; ramload = ld;
        #1;
        total++;
        if (ihit !== 1'b1 || imemload !== ld || ramaddr !== 32'h80) begin
            bad++;
            $display("[TB] FAIL midrst_refetch got ihit=%b load=%h addr=%h exp=1 %h 80",
                     ihit, imemload, ramaddr, ld);
        end
        imemREN = 1'b0;
        tick();
        ramstate = FREE;
    endtask

    // Each transaction: pick requests, predict grant from the priority rule,
    // wait a random RAM latency under the timeout, expect a single hit.
    task automatic test_random;
        bit           ireq, grant_d, exp_w;
        logic [1:0]   d;
        logic [W-1:0] ia, da, ds, exp_a, ld;
        int           lat;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            ireq = 1'($urandom_range(0, 1));
            d    = 2'($urandom_range(0, 3));
            if (!ireq && d == 2'b00) ireq = 1'b1;
            ia = $urandom; da = $urandom; ds = $urandom;
            imemREN = ireq; imemaddr = ia;
            dmemREN = d[0]; dmemWEN = d[1]; dmemaddr = da; dmemstore = ds;
            ramstate = FREE;
            grant_d = (d != 2'b00) && !(ifirst_m && ireq);
            exp_a   = grant_d ? da : ia;
            exp_w   = grant_d && d[1];
            lat     = $urandom_range(0, TO - 1);
            #1;
            total++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL rnd_idle[%0d] got ihit,dhit,ren,wen=%b exp=0000", n,
                         {ihit, dhit, ramREN, ramWEN});
            end
            tick();
            for (int c = 0; c <= lat; c++) begin
                if (c == lat) begin
                    ld = $urandom;
                    ramstate = ACCESS; ramload = ld;
                end else begin
                    ramstate = BUSY;
                end
                if ($urandom_range(0, 2) == 0) begin
                    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
                    imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom;
                end
                #1;
                total++;
                if ({ramREN, ramWEN} !== {!exp_w, exp_w} || ramaddr !== exp_a ||
                    (exp_w && ramstore !== ds)) begin
                    bad++;
                    $display("[TB] FAIL rnd_bus[%0d] got ren,wen=%b addr=%h store=%h exp=%b %h %h",
                             n, {ramREN, ramWEN}, ramaddr, ramstore, {!exp_w, exp_w}, exp_a, ds);
                end
                total++;
                if (c < lat) begin
                    if ({ihit, dhit} !== 2'b00) begin
                        bad++;
                        $display("[TB] FAIL rnd_early_hit[%0d] got ihit,dhit=%b exp=00", n, {ihit, dhit});
                    end
                end else begin
                    if ({ihit, dhit} !== {!grant_d, grant_d} ||
                        (grant_d ? dmemload : imemload) !== ld) begin
                        bad++;
                        $display("[TB] FAIL rnd_hit[%0d] got ihit,dhit=%b load=%h exp=%b %h", n,
                                 {ihit, dhit}, grant_d ? dmemload : imemload, {!grant_d, grant_d}, ld);
                    end
                end
                tick();
            end
            ifirst_m = grant_d;
        end
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ramstate = FREE;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nRST = 1'b1;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramload = '0; ramstate = FREE;
        ifirst_m = 1'b0;
        #2;
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_timeout();
        test_error_state();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
